// File: rtl/draw_text_overlay.sv
// Text-mode overlay: looks up characters in an external text RAM and font ROM and
// blends glyph pixels over a video stream with a fixed 3-clock pipeline latency.
module draw_text_overlay #(
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 2,
  parameter int X_CHAR_COUNT = 16,
  parameter int Y_CHAR_COUNT = 4,
  parameter int SCALE_COEFF  = 0,
  parameter int XPOS         = 0,
  parameter int YPOS         = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                               i_pclk,
  input  logic                               i_rst,
  input  logic [11:0]                        i_hcount,
  input  logic [11:0]                        i_vcount,
  input  logic                               i_hsync,
  input  logic                               i_hblnk,
  input  logic                               i_vsync,
  input  logic                               i_vblnk,
  input  logic [11:0]                        i_rgb,
  input  logic                               i_enable,
  input  logic                               i_opaque,
  input  logic [11:0]                        i_fg_rgb,
  input  logic [11:0]                        i_bg_rgb,
  input  logic                               i_cursor_en,
  input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] i_cursor_addr,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] o_char_addr,
  input  logic [7:0]                         i_char_code,
  output logic [11:0]                        o_font_addr,
  input  logic [7:0]                         i_font_row,
  output logic [11:0]                        o_hcount,
  output logic [11:0]                        o_vcount,
  output logic                               o_hsync,
  output logic                               o_hblnk,
  output logic                               o_vsync,
  output logic                               o_vblnk,
  output logic [11:0]                        o_rgb
);

  localparam int S     = SCALE_COEFF;
  localparam int AW    = X_ADDR_WIDTH + Y_ADDR_WIDTH;
  localparam int BOX_W = X_CHAR_COUNT * (8 << S);
  localparam int BOX_H = Y_CHAR_COUNT * (16 << S);

  logic [11:0] hrel, vrel;
  logic        in_box, cur_match, vsync_rise;

  // Frame-latched controls; only the vsync rising edge updates them.
  logic          vsync_d;
  logic          en_l, opq_l, cur_en_l;
  logic [11:0]   fg_l, bg_l;
  logic [AW-1:0] cur_addr_l;
  logic [7:0]    frame_cnt;
  logic          phase;

  // Stage 1 / stage 2 pipeline; sync vectors are {hsync, hblnk, vsync, vblnk}.
  logic [3:0]  s1_line;
  logic [2:0]  s1_bit, s2_bit;
  logic        s1_in_box, s2_in_box, s1_cm, s2_cm;
  logic [3:0]  s1_sync, s2_sync;
  logic [11:0] s1_rgb, s2_rgb, s1_h, s2_h, s1_v, s2_v;

  logic        pix;
  logic [11:0] color;
  logic        unused_bits;

  assign hrel = i_hcount - 12'(XPOS);
  assign vrel = i_vcount - 12'(YPOS);

  assign o_char_addr = {vrel[Y_ADDR_WIDTH+3+S -: Y_ADDR_WIDTH],
                        hrel[X_ADDR_WIDTH+2+S -: X_ADDR_WIDTH]};

  // Box limits use absolute counts so a box near 4095 never wraps into column 0.
  assign in_box = (int'(i_hcount) >= XPOS) && (int'(i_hcount) < XPOS + BOX_W) &&
                  (int'(i_vcount) >= YPOS) && (int'(i_vcount) < YPOS + BOX_H);
  assign cur_match  = in_box && (o_char_addr == cur_addr_l);
  assign vsync_rise = i_vsync && !vsync_d;

  assign o_font_addr = {i_char_code, s1_line};
  assign unused_bits = &{1'b0, hrel, vrel};

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      vsync_d    <= 1'b0;
      en_l       <= 1'b0;
      opq_l      <= 1'b0;
      cur_en_l   <= 1'b0;
      fg_l       <= '0;
      bg_l       <= '0;
      cur_addr_l <= '0;
      frame_cnt  <= '0;
      phase      <= 1'b1;
    end else begin
      vsync_d <= i_vsync;
      if (vsync_rise) begin
        en_l       <= i_enable;
        opq_l      <= i_opaque;
        fg_l       <= i_fg_rgb;
        bg_l       <= i_bg_rgb;
        cur_en_l   <= i_cursor_en;
        cur_addr_l <= i_cursor_addr;
      end
      // A disabled cursor parks the blink timer so re-enabling starts visible.
      if (!cur_en_l) begin
        frame_cnt <= '0;
        phase     <= 1'b1;
      end else if (vsync_rise) begin
        if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= !phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      s1_line <= '0; s1_bit <= '0; s1_in_box <= 1'b0; s1_cm <= 1'b0;
      s1_sync <= '0; s1_rgb <= '0; s1_h <= '0; s1_v <= '0;
      s2_bit <= '0; s2_in_box <= 1'b0; s2_cm <= 1'b0;
      s2_sync <= '0; s2_rgb <= '0; s2_h <= '0; s2_v <= '0;
      o_hcount <= '0; o_vcount <= '0;
      o_hsync <= 1'b0; o_hblnk <= 1'b0; o_vsync <= 1'b0; o_vblnk <= 1'b0;
      o_rgb <= '0;
    end else begin
      s1_line   <= vrel[3+S -: 4];
      s1_bit    <= hrel[2+S -: 3];
      s1_in_box <= in_box;
      s1_cm     <= cur_match;
      s1_sync   <= {i_hsync, i_hblnk, i_vsync, i_vblnk};
      s1_rgb    <= i_rgb;
      s1_h      <= i_hcount;
      s1_v      <= i_vcount;

      s2_bit    <= s1_bit;
      s2_in_box <= s1_in_box;
      s2_cm     <= s1_cm;
      s2_sync   <= s1_sync;
      s2_rgb    <= s1_rgb;
      s2_h      <= s1_h;
      s2_v      <= s1_v;

      o_hcount <= s2_h;
      o_vcount <= s2_v;
      o_hsync  <= s2_sync[3];
      o_hblnk  <= s2_sync[2];
      o_vsync  <= s2_sync[1];
      o_vblnk  <= s2_sync[0];
      o_rgb    <= color;
    end
  end

  always_comb begin
    pix   = i_font_row[3'd7 - s2_bit] ^ (s2_cm && phase && cur_en_l);
    color = s2_rgb;
    if (s2_sync[2] || s2_sync[0]) begin
      color = 12'h000;
    end else if (!en_l || !s2_in_box) begin
      color = s2_rgb;
    end else if (pix) begin
      color = fg_l;
    end else if (opq_l) begin
      color = bg_l;
    end
  end

endmodule

// File: doc/draw_text_overlay.md
DRAW_TEXT_OVERLAY -- requirements
Module: draw_text_overlay

Interface
REQ-001 Parameters SHALL be, one per line:
- X_ADDR_WIDTH, default 4: column address bits.
- Y_ADDR_WIDTH, default 2: row address bits.
- X_CHAR_COUNT, default 16: columns drawn, at most 2**X_ADDR_WIDTH.
- Y_CHAR_COUNT, default 4: rows drawn, at most 2**Y_ADDR_WIDTH.
- SCALE_COEFF, default 0: glyph scale, cell = (8<<S) x (16<<S) pixels.
- XPOS, default 0: left edge of text box, in pixels.
- YPOS, default 0: top edge of text box, in pixels.
- BLINK_FRAMES, default 30: frames per blink half-period, 1..255.

REQ-002 Ports SHALL be, one per line:
- i_pclk, in, 1: pixel clock, single clock domain.
- i_rst, in, 1: synchronous active-high reset.
- i_hcount, i_vcount, in, 12 each: pixel position.
- i_hsync, i_hblnk, i_vsync, i_vblnk, in, 1 each: timing signals.
- i_rgb, in, 12: underlying pixel colour.
- i_enable, in, 1: overlay on.
- i_opaque, in, 1: fill background pixels with i_bg_rgb.
- i_fg_rgb, i_bg_rgb, in, 12 each: glyph and background colours.
- i_cursor_en, in, 1: cursor display on.
- i_cursor_addr, in, X_ADDR_WIDTH+Y_ADDR_WIDTH: cursor cell, as {row, col}.
- o_char_addr, out, X_ADDR_WIDTH+Y_ADDR_WIDTH: text RAM address, as {row, col}.
- i_char_code, in, 8: text RAM data, valid 1 clock after o_char_addr.
- o_font_addr, out, 12: font ROM address, as {char_code, line[3:0]}.
- i_font_row, in, 8: font ROM row, valid 1 clock after o_font_addr; bit 7 is the leftmost pixel.
- o_hcount, o_vcount, out, 12 each: delayed pixel position.
- o_hsync, o_hblnk, o_vsync, o_vblnk, out, 1 each: delayed timing signals.
- o_rgb, out, 12: output colour.

Function
REQ-003 Relative coordinates SHALL be computed modulo 2**12: hrel = i_hcount - XPOS and vrel = i_vcount - YPOS.
REQ-004 o_char_addr SHALL be combinational: {vrel[Y_ADDR_WIDTH+3+S : 4+S], hrel[X_ADDR_WIDTH+2+S : 3+S]}.
REQ-005 Stage 1 SHALL register line = vrel[3+S:S], bit = hrel[2+S:S], the in-box flag, the cursor-match flag, and all timing and i_rgb inputs.
REQ-006 o_font_addr SHALL be combinational: {i_char_code, stage-1 line}.
REQ-007 Stage 2 SHALL register bit, in-box, cursor-match, timing, and rgb from stage 1.
REQ-008 o_rgb and all o_* timing/count outputs SHALL be registered from stage 2, giving total latency of exactly 3 clocks from input to output.
REQ-009 in-box SHALL be 1 iff XPOS <= i_hcount < XPOS + X_CHAR_COUNT*(8<<S) and YPOS <= i_vcount < YPOS + Y_CHAR_COUNT*(16<<S); this is a full-width compare, not wrap-based.
REQ-010 pix SHALL equal i_font_row[7 - stage-2 bit]; if cursor-match, blink phase = 1 and the latched cursor enable are all true, pix SHALL be inverted.
REQ-011 Output colour priority SHALL be:
- hblnk or vblnk (stage 2) -> 12'h000;
- else latched enable = 0 or in-box = 0 -> stage-2 rgb;
- else pix = 1 -> latched fg;
- else latched opaque = 1 -> latched bg;
- else stage-2 rgb.
REQ-012 Frame latch: on the i_vsync rising edge (i_vsync = 1 and previous value 0), the block SHALL capture i_enable, i_opaque, i_fg_rgb, i_bg_rgb, i_cursor_en and i_cursor_addr. Changes between edges SHALL have no effect on the output.
REQ-013 Blink: an 8-bit frame counter SHALL increment on each vsync rising edge. When the counter reaches BLINK_FRAMES-1 it SHALL return to 0 and the blink phase SHALL toggle. With BLINK_FRAMES = 1 the phase toggles every frame.
REQ-014 If the latched cursor enable = 0, the counter SHALL hold at 0 and the phase SHALL be forced to 1. Re-enabling therefore starts with the cursor visible.
REQ-015 cursor-match SHALL be 1 iff in-box and o_char_addr equals the latched cursor address. A cursor address outside the drawn grid never matches.
REQ-016 Addresses generated outside the box are don't-care and SHALL NOT affect o_rgb.

Reset
REQ-017 On i_rst = 1 at a clock edge, all pipeline registers and outputs SHALL go to 0 (o_rgb = 12'h000, syncs/blanks = 0, counts = 0).
REQ-018 On reset, the latched enable, opaque and cursor_en SHALL go to 0, the latched colours and cursor address to 0, the frame counter to 0, the blink phase to 1, and the previous-vsync register to 0.
REQ-019 Reset asserted mid-line SHALL take effect at the next edge. The output SHALL be background passthrough (enable = 0) until the first vsync rising edge after reset release.

Verification
REQ-020 Reset release with i_enable = 1 applied mid-frame -> o_rgb = delayed i_rgb until the first vsync rise; after it, glyph pixels show i_fg_rgb.
REQ-021 S=0, XPOS=YPOS=0, text RAM cell 0 = 8'h41, font row for 'A' line 0 = 8'h18, enabled, fg = 12'hFFF, i_rgb = 12'h00F, pixels h = 0..7 at v = 0 -> o_rgb sequence 00F, 00F, 00F, FFF, FFF, 00F, 00F, 00F, appearing 3 clocks after the input.
REQ-022 Same stimulus with i_opaque = 1, bg = 12'h800 -> 00F is replaced by 800 inside the box; pixel h = 128 (outside the 16-column box) stays 00F.
REQ-023 i_cursor_en = 1, cursor_addr = 0, BLINK_FRAMES = 2 -> cell 0 is inverted in frames 0 and 1 (phase 1), normal in frames 2 and 3, then inverted again.
REQ-024 hblnk = 1 over a glyph pixel -> o_rgb = 000. Toggling i_fg_rgb mid-frame -> no change until the next frame.
REQ-025 S=1, XPOS = 100 -> each font bit spans 2 pixels, and o_char_addr column increments every 16 pixels starting at h = 100.
